// File: rtl/fsk_demod.sv
// FSK demodulator and UART-style deframer: counts line edges per bit window, decides bits, strips start/stop framing.
// Optional even-parity bit between data and stop is enabled by defining FSK_DEMOD_PARITY_EN.
module fsk_demod #(
  parameter int BIT_CYCLES = 288,
  parameter int THRESH     = 5,
  parameter int MIN_EDGES  = 1
) (
  input  logic       mainclk,
  input  logic       reset,
  input  logic       fsk_in,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       carrier_det,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int         WW     = $clog2(BIT_CYCLES);
  localparam logic [7:0] THRESH_C = 8'(THRESH);
  localparam logic [7:0] MIN_C    = 8'(MIN_EDGES);

  typedef enum logic [1:0] {HUNT, DATA, PARITY, STOP} frame_state_t;

  logic          sync1, sync2, sync_prev;
  logic          rise;
  logic [WW-1:0] win_cnt;
  logic [7:0]    edge_cnt;
  logic [7:0]    cnt_final;
  logic          win_end;
  logic          carrier_lost;

  frame_state_t  state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rise    = sync2 & ~sync_prev;
  assign win_end = carrier_det && (win_cnt == WW'(BIT_CYCLES - 1));

  // Edge seen in the window-end cycle still belongs to the ending window.
  always_comb begin
    cnt_final = edge_cnt;
    if (rise && edge_cnt != 8'hFF) cnt_final = edge_cnt + 8'd1;
  end

  // Synchronizer, carrier acquisition/tracking and per-window bit decision.
  always_ff @(posedge mainclk) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync_prev    <= 1'b0;
      win_cnt      <= '0;
      edge_cnt     <= 8'd0;
      carrier_det  <= 1'b0;
      carrier_lost <= 1'b0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the sync chain really is two stages.
      sync1        <= fsk_in;
      sync2        <= sync1;
      sync_prev    <= sync2;
      bit_valid    <= 1'b0;
      carrier_lost <= 1'b0;
      if (!carrier_det) begin
        if (rise) begin
          carrier_det <= 1'b1;
          win_cnt     <= '0;
          edge_cnt    <= 8'd1;
        end
      end else if (win_end) begin
        win_cnt  <= '0;
        edge_cnt <= 8'd0;
        if (cnt_final < MIN_C) begin
          carrier_det  <= 1'b0;
          carrier_lost <= 1'b1;
        end else begin
          bit_valid <= 1'b1;
          bit_out   <= (cnt_final >= THRESH_C);
        end
      end else begin
        win_cnt  <= win_cnt + WW'(1);
        edge_cnt <= cnt_final;
      end
    end
  end

`ifdef FSK_DEMOD_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Framing FSM consumes the registered bit strobe, so byte events land one cycle after bit_valid.
  always_ff @(posedge mainclk) begin
    if (reset) begin
      state      <= HUNT;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FSK_DEMOD_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FSK_DEMOD_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (carrier_lost) begin
        if (state != HUNT) frame_err <= 1'b1;
        state <= HUNT;
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            if (!bit_out) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end
          DATA: begin
            shreg[bit_idx] <= bit_out;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef FSK_DEMOD_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef FSK_DEMOD_PARITY_EN
          PARITY: begin
            par_bit <= bit_out;
            state   <= STOP;
          end
`endif
          STOP: begin
            if (!bit_out) begin
              frame_err <= 1'b1;
`ifdef FSK_DEMOD_PARITY_EN
            end else if (^{shreg, par_bit}) begin
              parity_err <= 1'b1;
`endif
            end else begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_demod.sv
// Scoreboard bench for fsk_demod: stimulus pushes expected bits/byte events, a negedge monitor pops and compares.
// Parity frames are exercised when FSK_DEMOD_PARITY_EN is defined.
module tb_fsk_demod;
  localparam int BIT_CYCLES = 288;
  localparam int MARK       = 9;
  localparam int SPACE      = 2;

  logic       mainclk = 1'b0;
  logic       reset   = 1'b1;
  logic       fsk_in  = 1'b0;
  logic       bit_out, bit_valid, carrier_det;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err;

  fsk_demod #(.BIT_CYCLES(BIT_CYCLES), .THRESH(5), .MIN_EDGES(1)) dut (
    .mainclk    (mainclk),
    .reset      (reset),
    .fsk_in     (fsk_in),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .carrier_det(carrier_det),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 mainclk = ~mainclk;

  typedef enum int {EV_DV, EV_FE, EV_PE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  bit  exp_bits[$];
  ev_t exp_evs[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  hi_left  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic ev_t mk_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  // One line cycle: a rise holds the line high for 16 cycles.
  task automatic step(input bit rise_now);
    @(negedge mainclk);
    if (rise_now) begin
      fsk_in  = 1'b1;
      hi_left = 15;
    end else if (hi_left > 0) begin
      hi_left--;
      fsk_in = 1'b1;
    end else begin
      fsk_in = 1'b0;
    end
  endtask

  // n rises spaced 32 cycles apart; the acquiring rise adds one to the first window.
  task automatic drive_window(input int n, input int len, input bit first);
    int cnt;
    cnt = n + (first ? 1 : 0);
    if (len == BIT_CYCLES) begin
      if (cnt >= 5)      exp_bits.push_back(1'b1);
      else if (cnt >= 1) exp_bits.push_back(1'b0);
    end
    for (int t = 1; t <= len; t++) begin
      step((t % 32 == 0) && (t / 32 <= n));
      if (first && t == 2) check("carrier_det_before", carrier_det, 1'b0);
      if (first && t == 3) check("carrier_det_acquire", carrier_det, 1'b1);
    end
  endtask

  task automatic start_session();
    repeat (8) step(1'b0);
    step(1'b1);
    drive_window(MARK, BIT_CYCLES, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_ok);
    drive_window(SPACE, BIT_CYCLES, 1'b0);
    for (int i = 0; i < 8; i++) drive_window(d[i] ? MARK : SPACE, BIT_CYCLES, 1'b0);
`ifdef FSK_DEMOD_PARITY_EN
    drive_window((^d ^ par_flip) ? MARK : SPACE, BIT_CYCLES, 1'b0);
`endif
    drive_window(stop_ok ? MARK : SPACE, BIT_CYCLES, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bit_out"}, bit_out, 1'b0);
    check({tag, "_bit_valid"}, bit_valid, 1'b0);
    check({tag, "_carrier_det"}, carrier_det, 1'b0);
    check({tag, "_data_out"}, data_out, 8'h00);
    check({tag, "_data_valid"}, data_valid, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_parity_err"}, parity_err, 1'b0);
  endtask

  // Monitor: bit scoreboard with 288-cycle spacing, byte-event scoreboard with D+2 timing.
  int cyc = 0;
  int last_bv = 0;
  bit have_last = 1'b0;
  bit prev_bv = 1'b0;
  bit prev_cd = 1'b0;
  bit prev_cd_fall = 1'b0;

  always @(negedge mainclk) begin
    bit       cd_fall;
    int       nev;
    ev_t      e;
    ev_kind_t k;
    cyc++;
    cd_fall = prev_cd && !carrier_det;
    if (bit_valid) begin
      check("bit_expected", exp_bits.size() != 0, 1'b1);
      if (exp_bits.size() != 0) check("bit_out", bit_out, exp_bits.pop_front());
      if (have_last) check("bit_interval", cyc - last_bv, BIT_CYCLES);
      last_bv   = cyc;
      have_last = 1'b1;
    end
    if (!carrier_det) have_last = 1'b0;
    if (data_valid || frame_err || parity_err) begin
      nev = int'(data_valid) + int'(frame_err) + int'(parity_err);
      check("pulse_exclusive", nev, 1);
      check("byte_timing", prev_bv | prev_cd_fall, 1'b1);
      check("byte_expected", exp_evs.size() != 0, 1'b1);
      if (exp_evs.size() != 0) begin
        e = exp_evs.pop_front();
        k = data_valid ? EV_DV : (frame_err ? EV_FE : EV_PE);
        check("event_kind", k, e.kind);
        check("data_out", data_out, e.data);
      end
    end
    prev_bv      = bit_valid;
    prev_cd_fall = cd_fall;
    prev_cd      = carrier_det;
  end

  initial begin
    repeat (4) @(negedge mainclk);
    check_reset_values("reset");
    reset = 1'b0;

    // Three mark windows: bits of 1, no byte events.
    start_session();
    drive_window(MARK, BIT_CYCLES, 1'b0);
    drive_window(MARK, BIT_CYCLES, 1'b0);

    // Two good frames back to back, then idle.
    exp_evs.push_back(mk_ev(EV_DV, 8'hA5));
    exp_evs.push_back(mk_ev(EV_DV, 8'hC3));
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    drive_window(MARK, BIT_CYCLES, 1'b0);

    // Bad stop bit: frame error, data_out keeps last good byte.
    exp_evs.push_back(mk_ev(EV_FE, 8'hC3));
    send_frame(8'hA5, 1'b0, 1'b0);
    drive_window(MARK, BIT_CYCLES, 1'b0);

    // 4 edges -> 0 (start), 5 edges -> 1, 0 edges -> carrier loss mid-frame.
    exp_evs.push_back(mk_ev(EV_FE, 8'hC3));
    drive_window(4, BIT_CYCLES, 1'b0);
    drive_window(5, BIT_CYCLES, 1'b0);
    drive_window(0, BIT_CYCLES, 1'b0);
    repeat (3) step(1'b0);
    check("carrier_det_lost", carrier_det, 1'b0);

    // Reset during data bit 4 of 8'h3C, then a clean 8'h3C frame.
    start_session();
    drive_window(SPACE, BIT_CYCLES, 1'b0);
    drive_window(SPACE, BIT_CYCLES, 1'b0);
    drive_window(SPACE, BIT_CYCLES, 1'b0);
    drive_window(MARK, BIT_CYCLES, 1'b0);
    drive_window(MARK, BIT_CYCLES, 1'b0);
    drive_window(3, 100, 1'b0);
    @(negedge mainclk);
    reset   = 1'b1;
    fsk_in  = 1'b0;
    hi_left = 0;
    @(negedge mainclk);
    reset = 1'b0;
    check_reset_values("midframe_reset");
    start_session();
    exp_evs.push_back(mk_ev(EV_DV, 8'h3C));
    send_frame(8'h3C, 1'b0, 1'b1);
    drive_window(MARK, BIT_CYCLES, 1'b0);

`ifdef FSK_DEMOD_PARITY_EN
    exp_evs.push_back(mk_ev(EV_DV, 8'h07));
    send_frame(8'h07, 1'b0, 1'b1);
    exp_evs.push_back(mk_ev(EV_PE, 8'h07));
    send_frame(8'h07, 1'b1, 1'b1);
    exp_evs.push_back(mk_ev(EV_FE, 8'h07));
    send_frame(8'h07, 1'b1, 1'b0);
    drive_window(MARK, BIT_CYCLES, 1'b0);
`endif

    repeat (20) step(1'b0);
    check("bits_drained", exp_bits.size(), 0);
    check("events_drained", exp_evs.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
